// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: oversampling ratio, receiver
// state encoding and the baud divider calculation.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Clocks per oversampling tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head entry.
// Ports:
//   pll_clk, rst_n      clock, asynchronous active-low reset
//   push, push_data     write request and data (dropped when full, no pop)
//   full                count has reached DEPTH
//   pop                 read request, honoured only while valid
//   pop_data, valid     registered head entry and not-empty flag
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             pll_clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after_pop;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign full            = (count == CNT_W'(DEPTH));
  assign do_pop          = valid && pop;
  assign do_push         = push && (!full || do_pop);
  assign count_after_pop = count - CNT_W'(do_pop);
  assign count_nxt       = count_after_pop + CNT_W'(do_push);
  assign rd_ptr_nxt      = rd_ptr + PTR_W'(do_pop);

  // Storage array; no reset needed, entries are only read once written.
  always_ff @(posedge pll_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, count and the registered head. When the FIFO would be empty
  // after this cycle's pop, a concurrent push becomes the new head directly.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      pop_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(do_push);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      valid  <= (count_nxt != '0);
      if (do_push && (count_after_pop == '0)) begin
        pop_data <= push_data;
      end else if (count_after_pop != '0) begin
        pop_data <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and an output byte FIFO.
// Ports:
//   pll_clk, rst_n       clock, asynchronous active-low reset
//   rx_pin               raw asynchronous RX line, idles high
//   rx_data, rx_valid    head-of-FIFO byte and not-empty flag
//   rx_ready             consumer accept; pop on rx_valid && rx_ready
//   frame_err            one-cycle pulse when a stop bit samples low
//   overflow             sticky: a byte was dropped on a full FIFO
//   overflow_clr         clears overflow (a coincident set wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25125000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       pll_clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int unsigned DIV    = calc_div(CLK_HZ, BAUD);
  localparam int unsigned DIV_W  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned HALF   = OVERSAMPLE / 2;

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_fifo: baud divider below 2");
  end

  rx_state_e         state;
  logic              sync1;
  logic              rxs;
  logic [DIV_W-1:0]  div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              tick_c;
  logic              start_c;
  logic              stop_tick_c;
  logic              push_c;
  logic              pop_c;
  logic              full;

  // Two-flop synchroniser; idles high so reset does not look like a start.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rxs   <= sync1;
    end
  end

  assign start_c = (state == IDLE) && !rxs;
  assign tick_c  = (div_cnt == DIV_W'(DIV - 1));

  // Oversampling tick; restarted on the start edge to phase-align sampling.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (start_c || tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign stop_tick_c = (state == STOP) && tick_c &&
                       (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign push_c      = stop_tick_c && rxs;
  assign pop_c       = rx_valid && rx_ready;

  // Frame recovery FSM.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick_c) begin
            if (tick_cnt == TICK_W'(HALF - 1)) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rxs ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        DATA: begin
          if (tick_c) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
              shift[bit_idx] <= rxs;
              bit_idx        <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick_c) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow: a push that the FIFO cannot take this cycle.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_c && full && !pop_c) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .pll_clk  (pll_clk),
    .rst_n    (rst_n),
    .push     (push_c),
    .push_data(shift),
    .full     (full),
    .pop      (pop_c),
    .pop_data (rx_data),
    .valid    (rx_valid)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: drives serial frames on rx_pin and
// compares received bytes and flags against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ   = 1600000;
  localparam int unsigned BAUD     = 10000;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DIV      = 10;
  localparam int unsigned OS       = 16;
  localparam int          BIT_CLKS = 160;
  // Pin edge to rx_valid: 2 sync flops + 1 cycle to leave IDLE, then
  // half a bit + 8 data bits + stop bit of ticks.
  localparam int unsigned LATENCY  = 2 + 1 + DIV * (OS / 2 + OS * 9);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .pll_clk     (clk),
    .rst_n       (rst_n),
    .rx_pin      (rx_pin),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned last_drive_cyc = 0;
  int unsigned frame_start_cyc = 0;
  int unsigned rise_cyc = 0;
  int          fe_cnt = 0;
  logic        prev_valid = 1'b0;
  byte unsigned got[$];
  int unsigned  got_cyc[$];

  // Reference model: bytes the receiver should hold, plus expected overflow.
  byte unsigned exp_q[$];
  logic         exp_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the consumer side away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        got.push_back(rx_data);
        got_cyc.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  function automatic void model_frame(input byte unsigned b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive_bit(input logic b, input int clks);
    @(posedge clk);
    #1 rx_pin = b;
    last_drive_cyc = cyc;
    repeat (clks - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int clks);
    drive_bit(1'b0, clks);
    frame_start_cyc = last_drive_cyc;
    for (int i = 0; i < 8; i++) drive_bit(d[i], clks);
    drive_bit(1'b1, clks);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 rx_ready = r;
  endtask

  task automatic test_reset;
    idle(5);
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    n_checks++;
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", rx_data); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_nominal;
    int fe0;
    fe0 = fe_cnt;
    got.delete();
    set_ready(1'b1);
    send_byte(8'hA5, BIT_CLKS);
    idle(20);
    n_checks++;
    if (got.size() != 1) begin n_fail++; $display("FAIL nominal_count got %0d want 1", got.size()); end
    else begin
      n_checks++;
      if (got[0] !== 8'hA5) begin n_fail++; $display("FAIL nominal_data got %h want a5", got[0]); end
    end
    n_checks++;
    if (fe_cnt != fe0) begin n_fail++; $display("FAIL nominal_frame_err got %0d want 0", fe_cnt - fe0); end
    n_checks++;
    if (rise_cyc != frame_start_cyc + LATENCY) begin
      n_fail++;
      $display("FAIL nominal_latency got %0d want %0d", rise_cyc - frame_start_cyc, LATENCY);
    end
  endtask

  task automatic test_back_to_back;
    byte unsigned pat[3];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
    set_ready(1'b0);
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 3; i++) send_byte(8'(pat[i]), BIT_CLKS);
    idle(20);
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h00) begin
      n_fail++; $display("FAIL b2b_head got valid=%b data=%h want 1/00", rx_valid, rx_data);
    end
    set_ready(1'b1);
    idle(10);
    set_ready(1'b0);
    @(negedge clk);
    n_checks++;
    if (got.size() != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== pat[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, got[i], pat[i]); end
      end
      n_checks++;
      if (got_cyc[1] != got_cyc[0] + 1 || got_cyc[2] != got_cyc[1] + 1) begin
        n_fail++; $display("FAIL b2b_consecutive got cycles %0d %0d %0d", got_cyc[0], got_cyc[1], got_cyc[2]);
      end
    end
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", rx_valid); end
  endtask

  task automatic test_overflow;
    set_ready(1'b0);
    got.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i), BIT_CLKS);
      model_frame(8'(i));
      @(negedge clk);
      n_checks++;
      if (overflow !== exp_ovf) begin
        n_fail++; $display("FAIL ovf_flag_after_%0d got %b want %b", i, overflow, exp_ovf);
      end
    end
    @(posedge clk);
    #1 overflow_clr = 1'b1;
    @(posedge clk);
    #1 overflow_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
    set_ready(1'b1);
    idle(10);
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ovf_drain_count got %0d want %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h want %h", i, got[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_glitch;
    int fe0;
    fe0 = fe_cnt;
    set_ready(1'b1);
    got.delete();
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 400);
    n_checks++;
    if (got.size() != 0 || fe_cnt != fe0) begin
      n_fail++; $display("FAIL glitch_quiet got bytes=%0d frame_err=%0d want 0/0", got.size(), fe_cnt - fe0);
    end
    send_byte(8'hC3, BIT_CLKS);
    idle(20);
    n_checks++;
    if (got.size() != 1 || got[0] !== 8'hC3) begin
      n_fail++; $display("FAIL glitch_recover got count=%0d want 1 byte c3", got.size());
    end
  endtask

  task automatic test_frame_err;
    int fe0;
    logic [7:0] d;
    fe0 = fe_cnt;
    d = 8'h3C;
    set_ready(1'b1);
    got.delete();
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS + 1000);
    drive_bit(1'b1, 400);
    n_checks++;
    if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt - fe0); end
    n_checks++;
    if (got.size() != 0) begin n_fail++; $display("FAIL ferr_no_byte got %0d want 0", got.size()); end
    send_byte(8'h7E, BIT_CLKS);
    idle(20);
    n_checks++;
    if (got.size() != 1 || got[0] !== 8'h7E) begin
      n_fail++; $display("FAIL ferr_recover got count=%0d want 1 byte 7e", got.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'h81;
    set_ready(1'b0);
    send_byte(8'h99, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    idle(3);
    @(negedge clk);
    n_checks++;
    if ({rx_valid, rx_data, frame_err, overflow} !== 11'd0) begin
      n_fail++; $display("FAIL midreset_outputs got v=%b d=%h fe=%b ov=%b want all 0", rx_valid, rx_data, frame_err, overflow);
    end
    rx_pin = 1'b1;
    idle(5);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(200);
    got.delete();
    set_ready(1'b1);
    send_byte(8'h42, BIT_CLKS);
    idle(20);
    n_checks++;
    if (got.size() != 1 || got[0] !== 8'h42) begin
      n_fail++; $display("FAIL midreset_recover got count=%0d want 1 byte 42", got.size());
    end
  endtask

  task automatic test_baud_skew;
    int clks[2];
    clks[0] = 155;
    clks[1] = 165;
    set_ready(1'b1);
    for (int r = 0; r < 2; r++) begin
      got.delete();
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        exp_q.push_back(b);
        send_byte(b, clks[r]);
      end
      idle(20);
      n_checks++;
      if (got.size() != exp_q.size()) begin
        n_fail++; $display("FAIL skew%0d_count got %0d want %0d", clks[r], got.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_checks++;
          if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL skew%0d_data[%0d] got %h want %h", clks[r], i, got[i], exp_q[i]); end
        end
      end
    end
  endtask

  task automatic test_random_stall;
    logic done;
    done = 1'b0;
    got.delete();
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          exp_q.push_back(b);
          send_byte(b, BIT_CLKS);
          idle(int'($urandom_range(0, 50)));
        end
        idle(30);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    set_ready(1'b1);
    idle(20);
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got %0d want %0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_data[%0d] got %h want %h", i, got[i], exp_q[i]); end
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow got %b want 0", overflow); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_back_to_back;
    test_overflow;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_baud_skew;
    test_random_stall;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with a small output FIFO. Sits between the UART RX pin (ICE_9) and the PipelineC user logic.
- Synchronises the asynchronous pin, recovers bytes using 16x oversampling, checks the stop bit, and buffers bytes behind a valid/ready interface.
- Isolates the PipelineC pipeline from baud timing and short consumer stalls.

Parameters:
- CLK_HZ, 25125000, frequency of pll_clk in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; fixed at 16 (power of two).
- FIFO_DEPTH, 4, byte entries; power of two, at least 2.

Ports:
- pll_clk  in  1  sole clock, PLL output.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- rx_pin  in  1  raw UART RX pin; asynchronous, idles high.
- rx_data  out  8  head-of-FIFO byte.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow; set wins if set and clear coincide.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Sync flops go to 1, FSM to IDLE, all counters to 0, FIFO empty.
  - rx_valid=0, rx_data=0, frame_err=0, overflow=0.
- Input sync: two flops on rx_pin; all logic uses the second flop (rxs). Pin-to-FSM latency is 2 cycles.
- Tick generator:
  - DIV = (CLK_HZ + BAUD*8) / (BAUD*16), computed at elaboration, rounded to nearest. Elaboration error if DIV < 2.
  - Counter 0..DIV-1 emits a one-cycle tick at terminal count.
  - Counter reloads to 0 on the IDLE->START transition so sampling is phase-aligned to the start edge.
- FSM:
  - IDLE: on rxs==0 -> START, clear the tick count.
  - START: after 8 ticks (mid start bit), rxs==0 -> DATA with bit index 0; rxs==1 -> IDLE (glitch rejected, nothing reported).
  - DATA: every 16 ticks, sample rxs into shift[bit index], LSB first. After bit 7 -> STOP.
  - STOP: after 16 ticks, sample rxs.
    - 1: push the byte, -> IDLE.
    - 0: frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait until rxs==1 -> IDLE. A held-low line produces exactly one frame_err.
- Completion timing: a byte is pushed in the cycle the stop-bit tick lands. rx_valid rises on the next cycle.
- FIFO:
  - Synchronous, registered head: rx_data is valid whenever rx_valid=1 and stays stable until popped.
  - Pop happens when rx_valid && rx_ready.
  - Push while full and no pop in the same cycle: byte dropped, overflow set, contents unchanged.
  - Push while full with a pop in the same cycle: push accepted, count unchanged.
  - Push and pop on an empty FIFO: no bypass; the byte appears on the next cycle.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; full/empty come from a count of width log2(FIFO_DEPTH)+1.
- No timeouts. The receiver restarts on the first low sample after returning to IDLE; back-to-back frames with a 1-bit stop are supported.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - function calc_div(clk_hz, baud).
  - constant OVERSAMPLE=16.
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports pll_clk, rst_n, push, push_data, full, pop, pop_data, valid). It is reusable for the planned uart_tx block.

Test Plan:
Use CLK_HZ=1600000, BAUD=10000, so DIV=10 and one bit is 160 clocks.
- Send 0xA5 at nominal rate with rx_ready=1 -> rx_valid pulses once with rx_data=0xA5; frame_err stays 0; rx_valid rises 1 cycle after the stop-bit mid-sample.
- Send 0x00, 0xFF, 0x55 back-to-back with rx_ready=0 -> 3 entries held in order. Raise rx_ready -> 0x00, 0xFF, 0x55 on consecutive cycles, then rx_valid=0.
- Send 6 bytes 0x01..0x06 with rx_ready=0 (DEPTH=4) -> FIFO holds 0x01..0x04; overflow set at the 5th stop bit. Pulse overflow_clr -> overflow=0. Drain yields exactly 0x01..0x04.
- Send a 40-clock low glitch on rx_pin -> no byte, no frame_err, FSM back in IDLE.
- Send 0x3C with the stop bit forced low, holding the line low for 1000 clocks -> one frame_err pulse, no byte. Then send 0x7E -> received correctly.
- Assert rst_n low mid DATA of 0x81, release, then send 0x42 -> all outputs 0 during reset, no partial byte; 0x42 received correctly. Repeat at baud ±3% -> all bytes correct.
